// File: rtl/exc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl_if
// Description : Bundle of write-back, CSR and redirect signals exchanged
//               between the pipeline/CSR side (master) and exc_ctrl (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface exc_ctrl_if;
    // Write-back stage view of the committing instruction
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_exc_adef;
    logic        wb_exc_ine;
    logic        wb_exc_sys;
    logic        wb_exc_brk;
    logic        wb_exc_ale;
    logic [31:0] wb_badaddr;
    logic        wb_ertn;
    // Values coming from the csr block
    logic        need_interrupt;
    logic [31:0] csr_era;
    logic [31:0] csr_eentry;
    // Strobes and write data going to the csr block
    logic        is_exc;
    logic        is_ret;
    logic        Addr_exc;
    logic [5:0]  Ecode;
    logic [8:0]  EsubCode;
    logic [31:0] pc_to_era;
    logic [31:0] pc_to_badv;
    // Pipeline control
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    modport master (
        output wb_valid, wb_pc, wb_exc_adef, wb_exc_ine, wb_exc_sys,
               wb_exc_brk, wb_exc_ale, wb_badaddr, wb_ertn,
               need_interrupt, csr_era, csr_eentry,
        input  is_exc, is_ret, Addr_exc, Ecode, EsubCode, pc_to_era,
               pc_to_badv, flush, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  wb_valid, wb_pc, wb_exc_adef, wb_exc_ine, wb_exc_sys,
               wb_exc_brk, wb_exc_ale, wb_badaddr, wb_ertn,
               need_interrupt, csr_era, csr_eentry,
        output is_exc, is_ret, Addr_exc, Ecode, EsubCode, pc_to_era,
               pc_to_badv, flush, redirect_valid, redirect_pc, busy
    );
endinterface
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl
// Description : Exception/interrupt sequencer. Picks the highest-priority
//               event of the committing instruction, strobes the CSR trap or
//               return, holds a pipeline flush, then redirects fetch to
//               EENTRY (exception) or ERA (return).
// Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl #(
    parameter int FLUSH_CYCLES = 2    // legal range 1..15
) (
    input  wire logic  clk,
    input  wire logic  reset,
    exc_ctrl_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_TRAP     = 2'd1;
    localparam logic [1:0] c_ST_FLUSH    = 2'd2;
    localparam logic [1:0] c_ST_REDIRECT = 2'd3;

    localparam logic [3:0] c_FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);

    localparam logic [5:0] c_ECODE_INT   = 6'h00;
    localparam logic [5:0] c_ECODE_ADEF  = 6'h08;
    localparam logic [5:0] c_ECODE_ALE   = 6'h09;
    localparam logic [5:0] c_ECODE_SYS   = 6'h0B;
    localparam logic [5:0] c_ECODE_BRK   = 6'h0C;
    localparam logic [5:0] c_ECODE_INE   = 6'h0D;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_ret;        // current trap is an ERTN return
    logic        r_addr_exc;   // current trap is ADEF/ALE
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;
    logic [31:0] r_era;
    logic [31:0] r_badv;

    logic        w_take;
    logic        w_ret;
    logic        w_addr_exc;
    logic [5:0]  w_ecode;
    logic        w_badv_upd;
    logic [31:0] w_badv;

    // Event priority encoder for the instruction in write-back
    always_comb begin
        w_take     = 1'b0;
        w_ret      = 1'b0;
        w_addr_exc = 1'b0;
        w_ecode    = c_ECODE_INT;
        w_badv_upd = 1'b0;
        w_badv     = bus.wb_pc;
        if (bus.wb_valid) begin
            if (bus.need_interrupt) begin
                w_take  = 1'b1;
                w_ecode = c_ECODE_INT;
            end else if (bus.wb_exc_adef) begin
                w_take     = 1'b1;
                w_ecode    = c_ECODE_ADEF;
                w_addr_exc = 1'b1;
                w_badv_upd = 1'b1;
                w_badv     = bus.wb_pc;
            end else if (bus.wb_exc_ine) begin
                w_take  = 1'b1;
                w_ecode = c_ECODE_INE;
            end else if (bus.wb_exc_sys) begin
                w_take  = 1'b1;
                w_ecode = c_ECODE_SYS;
            end else if (bus.wb_exc_brk) begin
                w_take  = 1'b1;
                w_ecode = c_ECODE_BRK;
            end else if (bus.wb_exc_ale) begin
                w_take     = 1'b1;
                w_ecode    = c_ECODE_ALE;
                w_addr_exc = 1'b1;
                w_badv_upd = 1'b1;
                w_badv     = bus.wb_badaddr;
            end else if (bus.wb_ertn) begin
                w_take = 1'b1;
                w_ret  = 1'b1;
            end
        end
    end

    // Sequencer state, flush counter and latched cause fields
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= 4'd0;
            r_ret      <= 1'b0;
            r_addr_exc <= 1'b0;
            r_ecode    <= 6'd0;
            r_esubcode <= 9'd0;
            r_era      <= 32'd0;
            r_badv     <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_take) begin
                        r_state    <= c_ST_TRAP;
                        r_ret      <= w_ret;
                        r_addr_exc <= w_addr_exc;
                        r_era      <= bus.wb_pc;
                        // A return carries no cause, so the last cause stays visible
                        if (!w_ret) begin
                            r_ecode    <= w_ecode;
                            r_esubcode <= 9'd0;
                        end
                        if (w_badv_upd) begin
                            r_badv <= w_badv;
                        end
                    end
                end
                c_ST_TRAP: begin
                    r_state <= c_ST_FLUSH;
                    r_cnt   <= c_FLUSH_LOAD;
                end
                c_ST_FLUSH: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_ST_REDIRECT;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_REDIRECT: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are pure decodes of registered state; only redirect_pc sees CSR inputs
    assign bus.is_exc         = (r_state == c_ST_TRAP) && !r_ret;
    assign bus.is_ret         = (r_state == c_ST_TRAP) &&  r_ret;
    assign bus.Addr_exc       = (r_state == c_ST_TRAP) &&  r_addr_exc;
    assign bus.flush          = (r_state != c_ST_IDLE);
    assign bus.busy           = (r_state != c_ST_IDLE);
    assign bus.redirect_valid = (r_state == c_ST_REDIRECT);
    assign bus.redirect_pc    = (r_state != c_ST_REDIRECT) ? 32'd0 :
                                (r_ret ? bus.csr_era : bus.csr_eentry);
    assign bus.Ecode          = r_ecode;
    assign bus.EsubCode       = r_esubcode;
    assign bus.pc_to_era      = r_era;
    assign bus.pc_to_badv     = r_badv;

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exc_ctrl
// Description : Directed self-checking bench for exc_ctrl. Two instances
//               (FLUSH_CYCLES=2 and 1) share clock, reset and stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_ctrl;

    logic clk = 1'b0;
    logic reset;

    logic        wb_valid, wb_exc_adef, wb_exc_ine, wb_exc_sys;
    logic        wb_exc_brk, wb_exc_ale, wb_ertn, need_interrupt;
    logic [31:0] wb_pc, wb_badaddr, csr_era, csr_eentry;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle records, index k = cycles after the accepting edge
    logic        rec0_flush [1:10];
    logic        rec0_rv    [1:10];
    logic [31:0] rec0_rpc   [1:10];
    logic        rec0_exc   [1:10];
    logic        rec0_ret   [1:10];
    logic        rec0_addr  [1:10];
    logic        rec0_busy  [1:10];
    logic        rec1_flush [1:10];
    logic        rec1_rv    [1:10];

    always #5 clk = ~clk;

    exc_ctrl_if bus0();
    exc_ctrl_if bus1();

    assign bus0.wb_valid       = wb_valid;
    assign bus0.wb_pc          = wb_pc;
    assign bus0.wb_exc_adef    = wb_exc_adef;
    assign bus0.wb_exc_ine     = wb_exc_ine;
    assign bus0.wb_exc_sys     = wb_exc_sys;
    assign bus0.wb_exc_brk     = wb_exc_brk;
    assign bus0.wb_exc_ale     = wb_exc_ale;
    assign bus0.wb_badaddr     = wb_badaddr;
    assign bus0.wb_ertn        = wb_ertn;
    assign bus0.need_interrupt = need_interrupt;
    assign bus0.csr_era        = csr_era;
    assign bus0.csr_eentry     = csr_eentry;

    assign bus1.wb_valid       = wb_valid;
    assign bus1.wb_pc          = wb_pc;
    assign bus1.wb_exc_adef    = wb_exc_adef;
    assign bus1.wb_exc_ine     = wb_exc_ine;
    assign bus1.wb_exc_sys     = wb_exc_sys;
    assign bus1.wb_exc_brk     = wb_exc_brk;
    assign bus1.wb_exc_ale     = wb_exc_ale;
    assign bus1.wb_badaddr     = wb_badaddr;
    assign bus1.wb_ertn        = wb_ertn;
    assign bus1.need_interrupt = need_interrupt;
    assign bus1.csr_era        = csr_era;
    assign bus1.csr_eentry     = csr_eentry;

    exc_ctrl #(.FLUSH_CYCLES(2)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    exc_ctrl #(.FLUSH_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid = 1'b0; wb_exc_adef = 1'b0; wb_exc_ine = 1'b0; wb_exc_sys = 1'b0;
        wb_exc_brk = 1'b0; wb_exc_ale = 1'b0; wb_ertn = 1'b0; need_interrupt = 1'b0;
    endtask

    // Run n cycles after the accepting edge; optionally present a SYS in cycles lo..hi
    task automatic observe(input int n, input int lo, input int hi);
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k >= lo && k <= hi) begin
                clear_wb();
                wb_valid = 1'b1; wb_exc_sys = 1'b1; wb_pc = 32'h1c000999;
            end else begin
                clear_wb();
            end
            rec0_flush[k] = bus0.flush;
            rec0_rv[k]    = bus0.redirect_valid;
            rec0_rpc[k]   = bus0.redirect_pc;
            rec0_exc[k]   = bus0.is_exc;
            rec0_ret[k]   = bus0.is_ret;
            rec0_addr[k]  = bus0.Addr_exc;
            rec0_busy[k]  = bus0.busy;
            rec1_flush[k] = bus1.flush;
            rec1_rv[k]    = bus1.redirect_valid;
        end
    endtask

    initial begin
        int nf;
        int nr;
        reset = 1'b1;
        clear_wb();
        wb_pc = 32'd0; wb_badaddr = 32'd0; csr_era = 32'd0; csr_eentry = 32'd0;
        tick(); tick();

        // Reset state
        check_val("rst_busy",  32'(bus0.busy), 32'd0);
        check_val("rst_flush", 32'(bus0.flush), 32'd0);
        check_val("rst_ecode", 32'(bus0.Ecode), 32'd0);
        check_val("rst_era",   bus0.pc_to_era, 32'd0);
        check_val("rst_badv",  bus0.pc_to_badv, 32'd0);
        check_val("rst_rpc",   bus0.redirect_pc, 32'd0);
        reset = 1'b0;
        tick();

        // Flags without wb_valid are not an event
        wb_exc_sys = 1'b1; need_interrupt = 1'b1;
        tick(); tick();
        check_val("novalid_busy", 32'(bus0.busy), 32'd0);
        clear_wb();

        // SYS: full sequence timing on both instances
        csr_eentry = 32'h1c008000; csr_era = 32'h1c000200;
        wb_valid = 1'b1; wb_exc_sys = 1'b1; wb_pc = 32'h1c000100;
        observe(6, 99, 0);
        check_val("sys_ecode", 32'(bus0.Ecode), 32'h0B);
        check_val("sys_sub",   32'(bus0.EsubCode), 32'h0);
        check_val("sys_era",   bus0.pc_to_era, 32'h1c000100);
        check_val("sys_exc1",  32'(rec0_exc[1]), 32'd1);
        check_val("sys_exc2",  32'(rec0_exc[2]), 32'd0);
        check_val("sys_ret1",  32'(rec0_ret[1]), 32'd0);
        check_val("sys_addr1", 32'(rec0_addr[1]), 32'd0);
        nf = 0; nr = 0;
        for (int k = 1; k <= 6; k++) begin
            nf += int'(rec0_flush[k]);
            nr += int'(rec0_rv[k]);
        end
        check_val("sys_nflush", 32'(nf), 32'd4);
        check_val("sys_nredir", 32'(nr), 32'd1);
        check_val("sys_rv4",    32'(rec0_rv[4]), 32'd1);
        check_val("sys_rpc4",   rec0_rpc[4], 32'h1c008000);
        check_val("sys_busy5",  32'(rec0_busy[5]), 32'd0);
        // FLUSH_CYCLES=1 instance: redirect at t+3, flush for 3 cycles
        nf = 0;
        for (int k = 1; k <= 6; k++) nf += int'(rec1_flush[k]);
        check_val("f1_nflush", 32'(nf), 32'd3);
        check_val("f1_rv2",    32'(rec1_rv[2]), 32'd0);
        check_val("f1_rv3",    32'(rec1_rv[3]), 32'd1);
        check_val("f1_rv4",    32'(rec1_rv[4]), 32'd0);

        // ALE: badv from wb_badaddr
        wb_valid = 1'b1; wb_exc_ale = 1'b1; wb_pc = 32'h1c000110; wb_badaddr = 32'h00000003;
        observe(6, 99, 0);
        check_val("ale_exc1",  32'(rec0_exc[1]), 32'd1);
        check_val("ale_addr1", 32'(rec0_addr[1]), 32'd1);
        check_val("ale_addr2", 32'(rec0_addr[2]), 32'd0);
        check_val("ale_badv",  bus0.pc_to_badv, 32'h00000003);
        check_val("ale_ecode", 32'(bus0.Ecode), 32'h09);

        // ADEF together with ALE: ADEF wins, badv from wb_pc
        wb_valid = 1'b1; wb_exc_adef = 1'b1; wb_exc_ale = 1'b1; wb_pc = 32'h1c000120;
        observe(6, 99, 0);
        check_val("adef_addr1", 32'(rec0_addr[1]), 32'd1);
        check_val("adef_badv",  bus0.pc_to_badv, 32'h1c000120);
        check_val("adef_ecode", 32'(bus0.Ecode), 32'h08);

        // ERTN: return to ERA, badv untouched
        wb_valid = 1'b1; wb_ertn = 1'b1; wb_pc = 32'h1c000130;
        observe(6, 99, 0);
        check_val("ertn_ret1", 32'(rec0_ret[1]), 32'd1);
        check_val("ertn_exc1", 32'(rec0_exc[1]), 32'd0);
        check_val("ertn_rpc4", rec0_rpc[4], 32'h1c000200);
        check_val("ertn_era",  bus0.pc_to_era, 32'h1c000130);
        check_val("ertn_badv", bus0.pc_to_badv, 32'h1c000120);

        // ERTN + BRK: exception wins
        wb_valid = 1'b1; wb_ertn = 1'b1; wb_exc_brk = 1'b1; wb_pc = 32'h1c000140;
        observe(6, 99, 0);
        check_val("brk_ecode", 32'(bus0.Ecode), 32'h0C);
        check_val("brk_exc1",  32'(rec0_exc[1]), 32'd1);
        check_val("brk_ret1",  32'(rec0_ret[1]), 32'd0);
        check_val("brk_rpc4",  rec0_rpc[4], 32'h1c008000);

        // Interrupt + INE: interrupt wins; SYS offered during FLUSH is ignored
        wb_valid = 1'b1; need_interrupt = 1'b1; wb_exc_ine = 1'b1; wb_pc = 32'h1c000150;
        observe(9, 2, 3);
        nr = 0;
        for (int k = 1; k <= 9; k++) nr += int'(rec0_rv[k]);
        check_val("int_ecode",  32'(bus0.Ecode), 32'h00);
        check_val("int_era",    bus0.pc_to_era, 32'h1c000150);
        check_val("int_nredir", 32'(nr), 32'd1);
        check_val("int_busy9",  32'(rec0_busy[9]), 32'd0);

        // Reset during FLUSH: straight to IDLE, no redirect afterwards
        wb_valid = 1'b1; wb_exc_sys = 1'b1; wb_pc = 32'h1c000160;
        tick(); clear_wb();
        tick();
        check_val("rf_flushing", 32'(bus0.flush), 32'd1);
        reset = 1'b1;
        tick();
        check_val("rf_busy",  32'(bus0.busy), 32'd0);
        check_val("rf_flush", 32'(bus0.flush), 32'd0);
        check_val("rf_ecode", 32'(bus0.Ecode), 32'd0);
        reset = 1'b0;
        observe(6, 99, 0);
        nr = 0;
        for (int k = 1; k <= 6; k++) nr += int'(rec0_rv[k]);
        check_val("rf_nredir", 32'(nr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencer sitting between the write-back stage and the `csr` block. It prioritises exception flags and pending interrupts against the committing instruction, and drives the CSR trap/return strobes and cause fields. It then holds a pipeline flush for a fixed number of cycles and finally issues a one-cycle PC redirect to the exception entry (`EENTRY`) or return address (`ERA`).

## Interface
Parameters:
- `FLUSH_CYCLES`, 2, cycles spent in FLUSH state; legal range 1..15

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `wb_valid`  in  1  WB holds a committing instruction this cycle
- `wb_pc`  in  32  PC of WB instruction
- `wb_exc_adef`, `wb_exc_ine`, `wb_exc_sys`, `wb_exc_brk`, `wb_exc_ale`  in  1 each  exception flags carried to WB
- `wb_badaddr`  in  32  faulting data address (ALE)
- `wb_ertn`  in  1  WB instruction is ERTN
- `need_interrupt`  in  1  from `csr`
- `csr_era`, `csr_eentry`  in  32 each  current ERA / EENTRY from `csr`
- `is_exc`, `is_ret`, `Addr_exc`  out  1 each  CSR strobes
- `Ecode`  out  6, `EsubCode`  out  9  cause fields
- `pc_to_era`, `pc_to_badv`  out  32 each  CSR write data
- `flush`  out  1  kill all in-flight instructions
- `redirect_valid`  out  1, `redirect_pc`  out  32  fetch redirect
- `busy`  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, TRAP, FLUSH, REDIRECT.
- IDLE: an event is accepted only when `wb_valid`=1. The accepted event is the highest-priority true condition in this order:
  - interrupt (`need_interrupt`): Ecode 0x00, sub 0
  - ADEF: Ecode 0x08, sub 0, badv=`wb_pc`
  - INE: 0x0D
  - SYS: 0x0B
  - BRK: 0x0C
  - ALE: 0x09, badv=`wb_badaddr`
  - ERTN (return)
- No event: remain in IDLE, all strobes 0.
- On an accepted event, register `Ecode`/`EsubCode`/`pc_to_era`(=`wb_pc`)/`pc_to_badv`, latch kind (exc or ret), and go to TRAP.
- `pc_to_badv` is updated only for ADEF/ALE; otherwise it keeps its old value.
- TRAP (1 cycle):
  - exception kind: `is_exc`=1.
  - `Addr_exc`=1 only for ADEF/ALE.
  - ret kind: `is_ret`=1, `is_exc`=0.
  - Go to FLUSH with a 4-bit counter loaded to `FLUSH_CYCLES`-1.
- FLUSH: counter decrements each cycle. When counter==0, go to REDIRECT.
- REDIRECT (1 cycle): `redirect_valid`=1. `redirect_pc` = `csr_eentry` (exc) or `csr_era` (ret), sampled combinationally this cycle. Then go to IDLE.
- `flush`=1 in TRAP, FLUSH, REDIRECT. `busy`=1 in all non-IDLE states.
- While busy, all WB inputs and `need_interrupt` are ignored. Those instructions are being flushed. A pending interrupt is re-evaluated in IDLE.
- `Ecode`, `EsubCode`, `pc_to_era`, `pc_to_badv` hold their values between traps.
- ERTN with any exception flag set: the exception wins. ERTN together with `need_interrupt`: the interrupt wins, with ERA = `wb_pc`.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - all 1-bit outputs 0.
  - `Ecode`, `EsubCode`, `pc_to_era`, `pc_to_badv`, `redirect_pc` = 0.
- Reset mid-sequence: the next cycle is IDLE with all outputs at reset values; no redirect is issued.
- Event accepted at edge t: TRAP cycle t+1; FLUSH cycles t+2..t+1+`FLUSH_CYCLES`; REDIRECT at t+2+`FLUSH_CYCLES`; IDLE at t+3+`FLUSH_CYCLES`.
- With the default parameter, the sequence is 5 cycles and `flush` is high for 4 of them.
- All strobes are registered state decodes. `redirect_pc` is the only combinational path (CSR value to output).
- `csr` updates ERA/ESTAT/CRMD at the end of the TRAP cycle. EENTRY is stable by REDIRECT.
- Back-to-back events: a new event may be accepted in the first IDLE cycle after REDIRECT.

## Test plan
- SYS at `wb_pc`=0x1c000100, `csr_eentry`=0x1c008000:
  - `is_exc` pulses 1 cycle with `Ecode`=0x0B and `pc_to_era`=0x1c000100.
  - `flush` is high for 4 cycles.
  - `redirect_valid` pulses with `redirect_pc`=0x1c008000 at t+4.
- ALE with `wb_badaddr`=0x00000003: `Addr_exc`=1 together with `is_exc`, `pc_to_badv`=0x3, `Ecode`=0x09. Repeat with ADEF: `pc_to_badv`=`wb_pc`, `Ecode`=0x08.
- ERTN with `csr_era`=0x1c000200: `is_ret`=1, `is_exc`=0, `redirect_pc`=0x1c000200. ERTN+BRK in the same cycle: exception wins, `Ecode`=0x0C.
- `need_interrupt`=1 with INE set: interrupt wins, `Ecode`=0. A second SYS presented during FLUSH is ignored: exactly one redirect.
- Reset asserted during FLUSH: the next cycle has `busy`=0, `flush`=0, `Ecode`=0, and no `redirect_valid` ever appears. `FLUSH_CYCLES`=1 gives redirect at t+3.
